instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and instruction-memory loader. Accepts decoded instruction descriptions (mnemonic code plus register/immediate fields) over a valid/ready handshake and packs them into 32-bit words. The words use exactly the opcode/funct encodings the single-cycle controller decodes. Encoded words are buffered in a small FIFO and written sequentially into instruction memory through a stallable write port. It sits between the testbench/program source and the IM, ahead of the datapath.

---
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder.sv | 165 ++++++++++++++++
 tb/tb_instr_encoder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// +-----------------------------------------------------------------------------+
// | instr_encoder_if : instruction-description input and IM write-port bundle   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              im_we;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, im_ready,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, im_ready,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// +-----------------------------------------------------------------------------+
// | instr_encoder : MIPS instruction packer + FIFO-buffered IM loader           |
// | Option macro INSTR_ENC_HALF_EN enables LH/SH.  Rev 1.0                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              start_i,
  input  wire logic              finish_i,
  input  wire logic [ADDR_W-1:0] base_addr_i,
  instr_encoder_if.slave         bus,
  output logic [ADDR_W:0]        word_count_o,
  output logic                   err_illegal_o,
  output logic                   overflow_o,
  output logic                   done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wcnt_q;
  logic              err_q, ovf_q;

  logic [31:0] word;
  logic        legal, accept, push, pop, wrap;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Field forcing keeps don't-care fields zero so encodings are canonical.
  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (bus.in_op)
      5'd0:  word = 32'h0;
      5'd1:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000);
      5'd2:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010);
      5'd3:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100);
      5'd4:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101);
      5'd5:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100110);
      5'd6:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100111);
      5'd7:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b101010);
      5'd8:  word = r_word(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000000);
      5'd9:  word = r_word(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000010);
      5'd10: word = r_word(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
      5'd11: word = r_word(bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'b001001);
      5'd12: word = i_word(6'b001000, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd13: word = i_word(6'b001100, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd14: word = i_word(6'b001010, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd15: word = i_word(6'b000100, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd16: word = i_word(6'b000101, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd17: word = i_word(6'b100011, bus.in_rs, bus.in_rt, bus.in_imm);
`ifdef INSTR_ENC_HALF_EN
      5'd18: word = i_word(6'b100001, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd20: word = i_word(6'b101001, bus.in_rs, bus.in_rt, bus.in_imm);
`endif
      5'd19: word = i_word(6'b101011, bus.in_rs, bus.in_rt, bus.in_imm);
      5'd21: word = {6'b000010, bus.in_target};
      5'd22: word = {6'b000011, bus.in_target};
      default: legal = 1'b0;
    endcase
  end

  assign bus.in_ready = (state_q == S_RUN) && (cnt_q != FULL_CNT);
  assign bus.im_we    = (cnt_q != '0) && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = mem_q[rd_q];

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  assign pop    = bus.im_we && bus.im_ready;
  assign wrap   = pop && (addr_q == '1);

  always_comb begin
    state_d = state_q;
    if (start_i)
      state_d = S_RUN;
    else if (wrap)
      state_d = S_DONE;
    else if ((state_q == S_RUN) && finish_i)
      state_d = S_DRAIN;
    else if ((state_q == S_DRAIN) && (cnt_q == '0))
      state_d = S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        wr_q   <= '0;
        rd_q   <= '0;
        cnt_q  <= '0;
        addr_q <= base_addr_i;
        wcnt_q <= '0;
        err_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (accept && !legal) err_q <= 1'b1;
        if (pop) begin
          addr_q <= addr_q + ADDR_W'(1);
          wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
        end
        if (wrap) begin
          // Address space exhausted: anything still queued has nowhere to go.
          ovf_q <= 1'b1;
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          if (push) begin
            mem_q[wr_q] <= word;
            wr_q        <= wr_q + PTR_W'(1);
          end
          if (pop) rd_q <= rd_q + PTR_W'(1);
          case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
          endcase
        end
      end
    end
  end

  assign word_count_o  = wcnt_q;
  assign err_illegal_o = err_q;
  assign overflow_o    = ovf_q;
  assign done_o        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// +-----------------------------------------------------------------------------+
// | tb_instr_encoder : directed self-checking bench for instr_encoder           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_encoder;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic start, finish;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic err_illegal, overflow, done;
  int checks = 0;
  int errors = 0;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .finish_i     (finish),
    .base_addr_i  (base_addr),
    .bus          (bus.slave),
    .word_count_o (word_count),
    .err_illegal_o(err_illegal),
    .overflow_o   (overflow),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt;
    bus.in_valid = 1'b1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_w [4];
    int acc;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.im_ready = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    bus.in_valid = 1'b0;
    #3;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("rst_im_we", {31'h0, bus.im_we}, 32'h0);
    chk("rst_im_addr", 32'(bus.im_addr), 32'h0);
    chk("rst_im_wdata", bus.im_wdata, 32'h0);
    chk("rst_word_count", 32'(word_count), 32'h0);
    chk("rst_flags", {29'h0, err_illegal, overflow, done}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", {31'h0, bus.in_ready}, 32'h0);

    // ADD with shamt forced to zero
    bus.im_ready = 1'b1;
    do_start('0);
    drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0);
    chk("add_in_ready", {31'h0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("add_we", {31'h0, bus.im_we}, 32'h1);
    chk("add_addr", 32'(bus.im_addr), 32'h0);
    chk("add_wdata", bus.im_wdata, 32'h00221820);
    tick();
    chk("add_wc", 32'(word_count), 32'h1);
    chk("add_we_off", {31'h0, bus.im_we}, 32'h0);

    // back-to-back ADDI, LW, J
    do_start('0);
    drive(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0);
    tick();
    chk("addi_addr", 32'(bus.im_addr), 32'h0);
    chk("addi_wdata", bus.im_wdata, 32'h20220005);
    drive(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    tick();
    chk("lw_addr", 32'(bus.im_addr), 32'h1);
    chk("lw_wdata", bus.im_wdata, 32'h8FA8FFFC);
    drive(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    tick();
    bus.in_valid = 1'b0;
    chk("j_we", {31'h0, bus.im_we}, 32'h1);
    chk("j_addr", 32'(bus.im_addr), 32'h2);
    chk("j_wdata", bus.im_wdata, 32'h08000010);
    tick();
    chk("b2b_wc", 32'(word_count), 32'h3);

    // JR then back-pressure with continuous in_valid
    bus.im_ready = 1'b0;
    drive(5'd10, 5'd31, 5'd4, 5'd7, 5'd3, 16'h0, 26'h0);
    tick();
    exp_w[0] = 32'h03E00008; exp_w[1] = 32'h00000820;
    exp_w[2] = 32'h00001020; exp_w[3] = 32'h00001820;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(5'd1, 5'd0, 5'd0, 5'(acc + 1), 5'd0, 16'h0, 26'h0);
      chk("bp_in_ready", {31'h0, bus.in_ready}, (i < 3) ? 32'h1 : 32'h0);
      chk("bp_we", {31'h0, bus.im_we}, 32'h1);
      chk("bp_addr", 32'(bus.im_addr), 32'h3);
      chk("bp_wdata", bus.im_wdata, exp_w[0]);
      tick();
      if (i < 3) acc++;
    end
    bus.in_valid = 1'b0;
    bus.im_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_we", {31'h0, bus.im_we}, 32'h1);
      chk("drain_addr", 32'(bus.im_addr), 32'(3 + k));
      chk("drain_wdata", bus.im_wdata, exp_w[k]);
      tick();
    end
    chk("bp_we_off", {31'h0, bus.im_we}, 32'h0);
    chk("bp_wc", 32'(word_count), 32'h7);

    // illegal op
    drive(5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    chk("ill_in_ready", {31'h0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("ill_err", {31'h0, err_illegal}, 32'h1);
    chk("ill_we", {31'h0, bus.im_we}, 32'h0);
    tick();
    chk("ill_wc", 32'(word_count), 32'h7);

    // SH depends on build option
    do_start('0);
    chk("start_clr_err", {31'h0, err_illegal}, 32'h0);
    drive(5'd20, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0002, 26'h0);
    tick();
    bus.in_valid = 1'b0;
`ifdef INSTR_ENC_HALF_EN
    chk("sh_we", {31'h0, bus.im_we}, 32'h1);
    chk("sh_wdata", bus.im_wdata, 32'hA4850002);
    chk("sh_err", {31'h0, err_illegal}, 32'h0);
    tick();
    chk("sh_wc", 32'(word_count), 32'h1);
`else
    chk("sh_we", {31'h0, bus.im_we}, 32'h0);
    chk("sh_err", {31'h0, err_illegal}, 32'h1);
    tick();
    chk("sh_wc", 32'(word_count), 32'h0);
`endif

    // address-space overflow from the top two words
    bus.im_ready = 1'b0;
    do_start(10'd1022);
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    repeat (4) tick();
    bus.in_valid = 1'b0;
    chk("ovf_full", {31'h0, bus.in_ready}, 32'h0);
    bus.im_ready = 1'b1;
    chk("ovf_addr0", 32'(bus.im_addr), 32'd1022);
    chk("ovf_wdata0", bus.im_wdata, 32'h0);
    tick();
    chk("ovf_addr1", 32'(bus.im_addr), 32'd1023);
    chk("ovf_pre", {31'h0, overflow}, 32'h0);
    tick();
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    chk("ovf_done", {31'h0, done}, 32'h1);
    chk("ovf_we", {31'h0, bus.im_we}, 32'h0);
    chk("ovf_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("ovf_wc", 32'(word_count), 32'h2);

    // finish with three queued words
    bus.im_ready = 1'b0;
    do_start(10'd100);
    chk("fin_ovf_clr", {31'h0, overflow}, 32'h0);
    chk("fin_done_clr", {31'h0, done}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd0, 5'd0, 5'(i + 1), 5'd0, 16'h0, 26'h0);
      tick();
    end
    bus.in_valid = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("fin_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("fin_done0", {31'h0, done}, 32'h0);
    bus.im_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("fin_we", {31'h0, bus.im_we}, 32'h1);
      chk("fin_addr", 32'(bus.im_addr), 32'(100 + k));
      chk("fin_wdata", bus.im_wdata, exp_w[k + 1]);
      tick();
    end
    chk("fin_we_off", {31'h0, bus.im_we}, 32'h0);
    tick();
    chk("fin_done", {31'h0, done}, 32'h1);
    chk("fin_wc", 32'(word_count), 32'h3);
    do_start('0);
    chk("restart_done", {31'h0, done}, 32'h0);
    chk("restart_wc", 32'(word_count), 32'h0);
    chk("restart_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // asynchronous reset mid-operation
    bus.im_ready = 1'b0;
    drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("arst_pre_we", {31'h0, bus.im_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'h0, bus.im_we}, 32'h0);
    chk("arst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("arst_wdata", bus.im_wdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
